// File: rtl/parking_gate_controller.sv
// Entry/exit barrier sequencer for a single-lane car park: grants one barrier at a
// time, waits for a passage or timeout, then enforces a closed guard interval.
module parking_gate_controller #(
    parameter int CAPACITY     = 10,
    parameter int CW           = 8,
    parameter int OPEN_CYCLES  = 16,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          entry_req,
    input  logic          exit_req,
    input  logic          entry_pass,
    input  logic          exit_pass,
    output logic          entry_gate_open,
    output logic          exit_gate_open,
    output logic [CW-1:0] count,
    output logic          Full,
    output logic          entry_denied,
    output logic          timeout,
    output logic          busy
);

    // One timer serves both the open window and the closing guard interval.
    localparam int TMAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CAP        = CW'(CAPACITY);
    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN,
        CLOSING
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [CW-1:0] count_nx;
    logic          full_nx;
    logic          rr_exit;
    logic          rr_exit_nx;
    logic          denied_nx;
    logic          timeout_nx;
    logic          entry_req_q;
    logic          entry_ok;
    logic          exit_ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= CAP) ? CAP : v + 1'b1;
    endfunction

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign entry_ok = entry_req && (count < CAP);
    assign exit_ok  = exit_req && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            count        <= '0;
            Full         <= 1'b0;
            rr_exit      <= 1'b0;
            entry_denied <= 1'b0;
            timeout      <= 1'b0;
            entry_req_q  <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            count        <= count_nx;
            Full         <= full_nx;
            rr_exit      <= rr_exit_nx;
            entry_denied <= denied_nx;
            timeout      <= timeout_nx;
            entry_req_q  <= entry_req;
        end
    end

    always_comb begin
        state_nx        = state;
        timer_nx        = timer;
        count_nx        = count;
        rr_exit_nx      = rr_exit;
        denied_nx       = 1'b0;
        timeout_nx      = 1'b0;
        entry_gate_open = 1'b0;
        exit_gate_open  = 1'b0;
        busy            = 1'b1;

        case (state)
            IDLE: begin
                busy     = 1'b0;
                timer_nx = '0;
                // rr_exit low means entry wins a tie; every grant hands priority to the other side.
                if (entry_ok && (!exit_ok || !rr_exit)) begin
                    state_nx   = ENTRY_OPEN;
                    rr_exit_nx = 1'b1;
                end else if (exit_ok) begin
                    state_nx   = EXIT_OPEN;
                    rr_exit_nx = 1'b0;
                end
                denied_nx = entry_req && !entry_req_q && (count == CAP);
            end

            ENTRY_OPEN: begin
                entry_gate_open = 1'b1;
                if (entry_pass) begin
                    count_nx = sat_inc(count);
                    state_nx = CLOSING;
                    timer_nx = '0;
                end else if (timer == OPEN_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = CLOSING;
                    timer_nx   = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            EXIT_OPEN: begin
                exit_gate_open = 1'b1;
                if (exit_pass) begin
                    count_nx = sat_dec(count);
                    state_nx = CLOSING;
                    timer_nx = '0;
                end else if (timer == OPEN_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = CLOSING;
                    timer_nx   = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            CLOSING: begin
                if (timer == CLOSE_LAST) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase

        full_nx = (count_nx == CAP);
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: each transaction queues its expected
// barrier event, and a negedge monitor pops and compares when the DUT produces it.
module tb_parking_gate_controller;

    localparam int CAP   = 10;
    localparam int OPENC = 16;
    localparam int CLOSC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req, exit_req, entry_pass, exit_pass;
    logic       entry_gate_open, exit_gate_open;
    logic [7:0] count;
    logic       Full, entry_denied, timeout, busy;

    parking_gate_controller #(
        .CAPACITY(CAP), .CW(8), .OPEN_CYCLES(OPENC), .CLOSE_CYCLES(CLOSC)
    ) dut (
        .clk(clk), .reset(reset),
        .entry_req(entry_req), .exit_req(exit_req),
        .entry_pass(entry_pass), .exit_pass(exit_pass),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .count(count), .Full(Full), .entry_denied(entry_denied),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // side: 0 entry gate, 1 exit gate, 2 entry_denied pulse
    typedef struct {
        int side;
        int len;
        int cnt;
        int full;
        int to;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mcount   = 0;
    int   tmo_exp  = 0;
    int   tmo_seen = 0;
    int   mon_len  = 0;
    int   mon_side = 0;
    int   clen     = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (entry_gate_open || exit_gate_open) begin
            check("gate_excl", int'(entry_gate_open && exit_gate_open), 0);
            mon_side = entry_gate_open ? 0 : 1;
            mon_len++;
        end else if (mon_len > 0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_gate", 1, 0);
            end else begin
                e = sb.pop_front();
                check("gate_side", mon_side, e.side);
                check("open_len", mon_len, e.len);
                check("count", int'(count), e.cnt);
                check("full", int'(Full), e.full);
                check("timeout_flag", int'(timeout), e.to);
            end
            mon_len = 0;
        end
        if (entry_denied) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_deny", 1, 0);
            end else begin
                e = sb.pop_front();
                check("deny_side", 2, e.side);
            end
        end
        if (timeout) tmo_seen++;
        if (busy && !entry_gate_open && !exit_gate_open) begin
            clen++;
        end else if (!busy) begin
            if (clen > 0) check("closing_len", clen, CLOSC);
            clen = 0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_open();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (entry_gate_open || exit_gate_open) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("open_wait", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) wait_cycles(1);
        if (busy) check("idle_wait", 0, 1);
    endtask

    task automatic push_exp(input int side, input int len, input int to);
        exp_t x;
        x.side = side;
        x.len  = len;
        x.cnt  = mcount;
        x.full = (mcount == CAP) ? 1 : 0;
        x.to   = to;
        sb.push_back(x);
    endtask

    task automatic do_entry(input int d, input bit pass);
        if (pass) begin
            mcount++;
            push_exp(0, d + 1, 0);
        end else begin
            tmo_exp++;
            push_exp(0, OPENC, 1);
        end
        entry_req = 1'b1;
        wait_open();
        entry_req = 1'b0;
        if (pass) begin
            wait_cycles(d);
            entry_pass = 1'b1;
            wait_cycles(1);
            entry_pass = 1'b0;
        end
        wait_idle();
        wait_cycles(1);
    endtask

    task automatic do_exit(input int d);
        mcount--;
        push_exp(1, d + 1, 0);
        exit_req = 1'b1;
        wait_open();
        exit_req = 1'b0;
        wait_cycles(d);
        exit_pass = 1'b1;
        wait_cycles(1);
        exit_pass = 1'b0;
        wait_idle();
        wait_cycles(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        entry_req = 1'b0; exit_req = 1'b0; entry_pass = 1'b0; exit_pass = 1'b0;
        wait_cycles(3);
        check("rst_entry_gate", int'(entry_gate_open), 0);
        check("rst_exit_gate", int'(exit_gate_open), 0);
        check("rst_count", int'(count), 0);
        check("rst_full", int'(Full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_denied", int'(entry_denied), 0);
        check("rst_timeout", int'(timeout), 0);
        reset = 1'b0;
        wait_cycles(1);

        // Exit request with an empty facility is never granted.
        exit_req = 1'b1;
        wait_cycles(5);
        check("empty_exit_busy", int'(busy), 0);
        check("empty_exit_gate", int'(exit_gate_open), 0);
        exit_req = 1'b0;
        wait_cycles(1);

        do_entry(3, 1'b1);
        do_entry(0, 1'b0);

        // Stray exit_pass while the entry barrier is open.
        mcount++;
        push_exp(0, 4, 0);
        entry_req = 1'b1;
        wait_open();
        entry_req = 1'b0;
        wait_cycles(1);
        exit_pass = 1'b1;
        wait_cycles(1);
        exit_pass = 1'b0;
        check("stray_count", int'(count), 1);
        wait_cycles(1);
        entry_pass = 1'b1;
        wait_cycles(1);
        entry_pass = 1'b0;
        wait_idle();
        wait_cycles(1);

        // Pass lands on the last open cycle: counted, no timeout.
        do_entry(OPENC - 1, 1'b1);

        for (int i = 0; i < 7; i++) do_entry(i, 1'b1);
        check("filled_count", int'(count), CAP);
        check("filled_full", int'(Full), 1);

        // Held entry request while full: one denial, gate stays shut.
        push_exp(2, 0, 0);
        entry_req = 1'b1;
        wait_cycles(6);
        check("deny_gate", int'(entry_gate_open), 0);
        check("deny_busy", int'(busy), 0);
        entry_req = 1'b0;
        wait_cycles(2);

        do_exit(2);
        for (int i = 0; i < 4; i++) do_exit(i);

        // Both sides held: grants alternate starting with entry.
        mcount++; push_exp(0, 2, 0);
        mcount--; push_exp(1, 2, 0);
        mcount++; push_exp(0, 2, 0);
        mcount--; push_exp(1, 2, 0);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_open();
            if (i == 3) begin
                entry_req = 1'b0;
                exit_req  = 1'b0;
            end
            wait_cycles(1);
            entry_pass = 1'b1;
            exit_pass  = 1'b1;
            wait_cycles(1);
            entry_pass = 1'b0;
            exit_pass  = 1'b0;
        end
        wait_idle();
        wait_cycles(1);
        check("alt_count", int'(count), 5);

        do_exit(1);
        do_exit(0);

        // Reset while the exit barrier is open with count=3.
        mcount = 0;
        push_exp(1, 1, 0);
        exit_req = 1'b1;
        wait_open();
        exit_req = 1'b0;
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check("mid_rst_entry_gate", int'(entry_gate_open), 0);
        check("mid_rst_exit_gate", int'(exit_gate_open), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_full", int'(Full), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_timeout", int'(timeout), 0);
        check("mid_rst_denied", int'(entry_denied), 0);
        wait_cycles(1);

        do_entry(2, 1'b1);

        wait_cycles(3);
        check("sb_empty", sb.size(), 0);
        check("timeout_pulses", tmo_seen, tmo_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequencing and arbitration controller for a single-lane parking facility with separate entry and exit barriers sharing one occupancy counter. It grants one barrier at a time and holds that barrier open until a car passes or a timeout expires. It enforces a closing guard interval and updates occupancy and the `Full` flag only on confirmed passages. It replaces free-running in/out counting at the top level and drives barrier actuators directly.

## Interface
- `CAPACITY`, default 10: number of slots; `count` never exceeds it.
- `CW`, default 8: width of `count`; must satisfy `CAPACITY < 2**CW`.
- `OPEN_CYCLES`, default 16: maximum number of cycles a barrier stays open waiting for a passage; minimum 2.
- `CLOSE_CYCLES`, default 4: guard interval with both barriers closed after each open; minimum 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `entry_req`  in  1  car waiting at entry barrier (level).
- `exit_req`  in  1  car waiting at exit barrier (level).
- `entry_pass`  in  1  car crossed the entry sensor (1-cycle pulse or level).
- `exit_pass`  in  1  car crossed the exit sensor.
- `entry_gate_open`  out  1  entry barrier open command.
- `exit_gate_open`  out  1  exit barrier open command.
- `count`  out  CW  current occupancy.
- `Full`  out  1  high when `count == CAPACITY`.
- `entry_denied`  out  1  1-cycle pulse: entry request refused because the facility is full.
- `timeout`  out  1  1-cycle pulse: an open barrier expired without a passage.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values:
  - all outputs 0, including `count = 0` and `Full = 0`.
  - state IDLE, open timer 0, round-robin pointer = entry priority.
  - edge-detect register for `entry_req` is 0.
- States:
  - IDLE: both barriers closed. Evaluates eligibility:
    - entry is eligible when `entry_req && count < CAPACITY`.
    - exit is eligible when `exit_req && count > 0`.
  - IDLE transitions:
    - exactly one eligible: go to its OPEN state.
    - both eligible: the round-robin pointer picks the winner, then flips to favour the other side.
    - a single grant also sets the pointer to favour the other side.
    - neither eligible: stay in IDLE.
  - ENTRY_OPEN / EXIT_OPEN: the matching `*_gate_open` is high and the timer increments each cycle from 0.
    - the matching `*_pass` is sampled high: `count` changes by ±1 and the FSM goes to CLOSING.
    - otherwise, the timer reaching `OPEN_CYCLES-1`: `timeout` pulses, `count` is unchanged, and the FSM goes to CLOSING.
    - pass and timer expiry in the same cycle: the pass wins and there is no `timeout`.
  - CLOSING: both barriers closed. Stays exactly `CLOSE_CYCLES` cycles, then returns to IDLE.
- Only one barrier is ever open; the two `*_gate_open` outputs are mutually exclusive.
- Pass pulses in a non-matching state (IDLE, CLOSING, other barrier open) are ignored.
- `Full` is registered and updated in the same edge as `count`; it always equals `count == CAPACITY`.
- `entry_denied` behaviour:
  - pulses on a rising edge of `entry_req`, while in IDLE, with `count == CAPACITY`.
  - a held request pulses once only.
  - a rising edge outside IDLE is not denied; it is re-evaluated in IDLE as level eligibility.
- Arithmetic: `count` saturates by construction. Entry is never granted at `CAPACITY` and exit is never granted at 0, so no wrap is possible.
- Reset mid-operation: barriers close on the reset edge, `count` clears, and any pending passage is discarded.

## Timing
- Request latency: a request sampled eligible in IDLE at edge N gives `*_gate_open` high after edge N, and `busy` high from the same edge.
- Passage latency: a pass sampled at edge M updates `count`/`Full` after M, deasserts the gate after M, and enters CLOSING after M.
- IDLE is re-entered after edge `M+CLOSE_CYCLES`; a new grant is possible at the next edge.
- Timeout: with no pass, the gate stays high for exactly `OPEN_CYCLES` cycles. The `timeout` pulse coincides with the first CLOSING cycle.
- Minimum turnaround per car is `1 + (cycles open) + CLOSE_CYCLES`.

## Test plan
- Single entry: reset, `entry_req=1`, `entry_pass` pulse 3 cycles after the gate opens -> `entry_gate_open` high for 4 cycles, `count` goes 0→1, CLOSING for 4 cycles, then `busy=0`.
- Fill and deny: 10 entries with default parameters -> `count=10`, `Full=1`. An 11th `entry_req` rise -> one `entry_denied` pulse, gate never opens. One exit -> `count=9`, `Full=0`.
- Simultaneous requests: `count=5`, `entry_req` and `exit_req` held high with passes each time -> grants alternate entry, exit, entry, exit, and `count` ends at 5.
- Timeout: `entry_req` with no `entry_pass` -> gate high exactly 16 cycles, `timeout` pulses once, `count` unchanged.
- Boundary guards:
  - `exit_req` at `count=0` -> no grant, `busy=0`.
  - a stray `exit_pass` during ENTRY_OPEN -> ignored, and `count` increments only on `entry_pass`.
  - pass and timeout in the same cycle -> counted, no `timeout`.
- Reset mid-open: `reset` asserted during EXIT_OPEN with `count=3` -> the next cycle has all outputs 0 and state IDLE.
